instruction_controller: RTL and testbench



---
 rtl/controller_pkg.sv | 50 +++++
 rtl/instr_decoder.sv | 53 +++++
 rtl/instruction_controller.sv | 145 ++++++++++++++
 tb/tb_instruction_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared encodings for the instruction controller: FSM states, instruction classes,
// opcode/op/vsel constants and IR field positions. CTRL_HALT_EN adds the HALT state.
package controller_pkg;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int OP_HI  = 12;
  localparam int OP_LO  = 11;
  localparam int RN_HI  = 10;
  localparam int RN_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_MDATA = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_PC    = 2'b11;

  localparam logic [1:0] ALUOP_PASS = 2'b00;

`ifdef CTRL_HALT_EN
  typedef enum logic [2:0] {
    ST_WAIT, ST_DECODE, ST_GET_A, ST_GET_B, ST_OPERATE, ST_WRITE_REG, ST_WRITE_IMM, ST_HALT
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_WAIT, ST_DECODE, ST_GET_A, ST_GET_B, ST_OPERATE, ST_WRITE_REG, ST_WRITE_IMM
  } state_t;
`endif

  typedef enum logic [2:0] {
    CLS_ILLEGAL, CLS_MOV_IMM, CLS_MOV_REG, CLS_ADD, CLS_CMP, CLS_AND, CLS_MVN, CLS_HALT
  } instr_class_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational IR decode: instruction class, register indices, shift/op fields and
// sign-extended immediates. Opcode 111 decodes as HALT only when CTRL_HALT_EN is defined.
module instr_decoder
  import controller_pkg::*;
#(
  parameter int width = 16
) (
  input  logic [width-1:0] ir,
  output instr_class_t     cls,
  output logic [2:0]       rn,
  output logic [2:0]       rd,
  output logic [2:0]       rm,
  output logic [1:0]       op,
  output logic [1:0]       sh,
  output logic [width-1:0] sximm5,
  output logic [width-1:0] sximm8
);

  logic [2:0] opcode;

  assign opcode = ir[OPC_HI:OPC_LO];
  assign op     = ir[OP_HI:OP_LO];
  assign rn     = ir[RN_HI:RN_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign sh     = ir[SH_HI:SH_LO];
  assign rm     = ir[RM_HI:RM_LO];

  assign sximm5 = {{(width-5){ir[4]}}, ir[4:0]};
  assign sximm8 = {{(width-8){ir[7]}}, ir[7:0]};

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
        else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
      end
      OPC_ALU: begin
        case (op)
          OP_ADD:  cls = CLS_ADD;
          OP_CMP:  cls = CLS_CMP;
          OP_AND:  cls = CLS_AND;
          default: cls = CLS_MVN;
        endcase
      end
`ifdef CTRL_HALT_EN
      OPC_HALT: cls = CLS_HALT;
`endif
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/instruction_controller.sv
// Multi-cycle Moore controller: IR, state register and per-state datapath strobes.
// Optional CTRL_HALT_EN makes opcode 111 park the controller in HALT until reset.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   WAIT       | idle, w=1; load captures IR, s launches
//   DECODE     | classify IR, pick first datapath phase
//   GET_A      | read Rn into A
//   GET_B      | read Rm into B
//   OPERATE    | shift/ALU into C (and status for CMP)
//   WRITE_REG  | write C back to Rd
//   WRITE_IMM  | write sximm8 to Rn
//   HALT       | stopped, only reset leaves (CTRL_HALT_EN)
module instruction_controller
  import controller_pkg::*;
#(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] in,
  input  logic             load,
  input  logic             s,
  output logic             w,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             loada,
  output logic             loadb,
  output logic             asel,
  output logic             bsel,
  output logic             loadc,
  output logic             loads,
  output logic             write,
  output logic [1:0]       vsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [width-1:0] sximm5,
  output logic [width-1:0] sximm8
);

  state_t           state;
  state_t           state_next;
  logic [width-1:0] ir;

  instr_class_t cls;
  logic [2:0]   rn;
  logic [2:0]   rd;
  logic [2:0]   rm;
  logic [1:0]   op;
  logic [1:0]   sh;

  instr_decoder #(.width(width)) u_decoder (
    .ir     (ir),
    .cls    (cls),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .op     (op),
    .sh     (sh),
    .sximm5 (sximm5),
    .sximm8 (sximm8)
  );

  // IR only changes in WAIT, so it is stable for the whole instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_WAIT;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == ST_WAIT && load) ir <= in;
    end
  end

  always_comb begin
    state_next = state;
    w          = 1'b0;
    readnum    = 3'd0;
    writenum   = 3'd0;
    loada      = 1'b0;
    loadb      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    write      = 1'b0;
    vsel       = VSEL_C;
    shift      = 2'b00;
    ALUop      = ALUOP_PASS;

    case (state)
      ST_WAIT: begin
        w = 1'b1;
        if (s) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        case (cls)
          CLS_MOV_IMM:                state_next = ST_WRITE_IMM;
          CLS_MOV_REG, CLS_MVN:       state_next = ST_GET_B;
          CLS_ADD, CLS_CMP, CLS_AND:  state_next = ST_GET_A;
`ifdef CTRL_HALT_EN
          CLS_HALT:                   state_next = ST_HALT;
`endif
          default:                    state_next = ST_WAIT;
        endcase
      end
      ST_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        state_next = ST_GET_B;
      end
      ST_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        state_next = ST_OPERATE;
      end
      ST_OPERATE: begin
        // MOV reg and MVN force A to zero so the ALU passes (or inverts) shifted B.
        shift      = sh;
        loadc      = 1'b1;
        ALUop      = (cls == CLS_MOV_REG) ? ALUOP_PASS : op;
        asel       = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
        loads      = (cls == CLS_CMP);
        state_next = (cls == CLS_CMP) ? ST_WAIT : ST_WRITE_REG;
      end
      ST_WRITE_REG: begin
        writenum   = rd;
        vsel       = VSEL_C;
        write      = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WRITE_IMM: begin
        writenum   = rn;
        vsel       = VSEL_IMM8;
        write      = 1'b1;
        state_next = ST_WAIT;
      end
`ifdef CTRL_HALT_EN
      ST_HALT: state_next = ST_HALT;
`endif
      default: state_next = ST_WAIT;
    endcase
  end

endmodule

// File: tb/tb_instruction_controller.sv
// Directed bench for instruction_controller: a reference model pushes the expected
// per-cycle output vector of each instruction, and each cycle pops and compares it.
module tb_instruction_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum, writenum;
  logic        loada, loadb, asel, bsel, loadc, loads, write;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm5, sximm8;

  int tests = 0;
  int fails = 0;

  typedef logic [19:0] ovec_t;
  ovec_t exp_q[$];
  string tag_q[$];

  instruction_controller #(.width(16)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads), .write(write),
    .vsel(vsel), .shift(shift), .ALUop(ALUop), .sximm5(sximm5), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  // {w, readnum, writenum, loada, loadb, asel, bsel, loadc, loads, write, vsel, shift, ALUop}
  function automatic ovec_t mk(input logic ww, input logic [2:0] rn, input logic [2:0] wn,
                               input logic la, input logic lb, input logic as, input logic lc,
                               input logic ls, input logic wr, input logic [1:0] vs,
                               input logic [1:0] sh, input logic [1:0] alu);
    return {ww, rn, wn, la, lb, as, 1'b0, lc, ls, wr, vs, sh, alu};
  endfunction

  function automatic ovec_t outvec();
    return {w, readnum, writenum, loada, loadb, asel, bsel, loadc, loads, write, vsel, shift, ALUop};
  endfunction

  function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
    logic [15:0] r;
    r = v;
    for (int i = bits; i < 16; i++) r[i] = v[bits-1];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input ovec_t v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // Spec-level reference: expected outputs for every cycle from DECODE back to WAIT.
  task automatic push_expected(input string name, input logic [15:0] instr);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    opc = instr[15:13]; op = instr[12:11]; rn = instr[10:8];
    rd = instr[7:5]; sh = instr[4:3]; rm = instr[2:0];
    push({name, ".decode"}, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    if (opc == 3'b110 && op == 2'b10) begin
      push({name, ".write_imm"}, mk(0, 0, rn, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00));
    end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
      push({name, ".get_b"}, mk(0, rm, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
      push({name, ".operate"}, mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, sh,
                                  (opc == 3'b101) ? 2'b11 : 2'b00));
      push({name, ".write_reg"}, mk(0, 0, rd, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00));
    end else if (opc == 3'b101) begin
      push({name, ".get_a"}, mk(0, rn, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
      push({name, ".get_b"}, mk(0, rm, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
      push({name, ".operate"}, mk(0, 0, 0, 0, 0, 0, 1, (op == 2'b01), 0, 2'b00, sh, op));
      if (op != 2'b01)
        push({name, ".write_reg"}, mk(0, 0, rd, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00));
    end
    push({name, ".wait"}, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
  endtask

  // mode 0: clean; 1: garbage load/s while busy; 2: s held high throughout.
  task automatic run_instr(input string name, input logic [15:0] instr, input int mode);
    ovec_t e;
    string t;
    @(negedge clk);
    in = instr; load = 1'b1; s = 1'b1;
    push_expected(name, instr);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, outvec(), e);
      load = 1'b0;
      s    = (mode == 2);
      if (mode == 1 && exp_q.size() > 0) begin
        in = 16'h1F7F; load = 1'b1; s = 1'b1;
      end
    end
    chk({name, ".sximm8"}, {4'h0, sximm8}, {4'h0, sx(instr, 8)});
    chk({name, ".sximm5"}, {4'h0, sximm5}, {4'h0, sx(instr, 5)});
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset.outputs", outvec(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    chk("reset.sximm", {4'h0, sximm5 | sximm8}, 20'h0);
    reset = 1'b0;

    // Reset asserted in GET_B of an ADD aborts it before write-back.
    @(negedge clk); in = 16'hA0A1; load = 1'b1; s = 1'b1;
    @(negedge clk); load = 1'b0; s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.in_get_b", outvec(), mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort.wait", outvec(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    chk("abort.ir_cleared", {4'h0, sximm8}, 20'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("abort.idle%0d", i), {18'h0, w, write}, {18'h0, 1'b1, 1'b0});
    end

    run_instr("mov_imm", 16'hD105, 0);
    run_instr("add", 16'hA0A1, 1);
    run_instr("cmp", 16'hA900, 0);
    run_instr("mov_reg", 16'hC0F2, 0);
    run_instr("mvn", 16'hBB43, 0);
    run_instr("and", 16'hB2CC, 1);

    // s held high: WAIT lasts one cycle, then the same CMP launches again.
    run_instr("cmp_hold", 16'hA900, 2);
    @(negedge clk);
    chk("relaunch.decode", {19'h0, w}, 20'h0);
    s = 1'b0;
    repeat (3) @(negedge clk);
    chk("relaunch.operate_loads", {18'h0, loads, loadc}, 20'h3);
    @(negedge clk);
    chk("relaunch.wait", {19'h0, w}, 20'h1);

`ifdef CTRL_HALT_EN
    @(negedge clk); in = 16'hE000; load = 1'b1; s = 1'b1;
    @(negedge clk);
    chk("halt.decode", outvec(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 10; i++) begin
      in = 16'hD105; load = 1'b1; s = (i % 2 == 0);
      @(negedge clk);
      chk($sformatf("halt.hold%0d", i), outvec(),
          mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    end
    load = 1'b0; s = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("halt.reset_recovers", outvec(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    run_instr("after_halt", 16'hD105, 0);
`else
    run_instr("illegal_111", 16'hE000, 0);
    run_instr("illegal_000", 16'h1234, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
